// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle MIPS control FSM (master) and its datapath (slave).
// The datapath supplies the opcode; the FSM drives every select, enable and status flag.
interface multicycle_control_fsm_if;
    logic [5:0] opcode;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [2:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  opcode,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        output MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
        output instr_done, illegal_op, state_dbg
    );

    modport slave (
        output opcode,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        input  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
        input  instr_done, illegal_op, state_dbg
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main control unit: sequences fetch/decode/execute/memory/writeback and
// drives the datapath selects. Outputs are registered from the next-state decode.
module multicycle_control_fsm #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    multicycle_control_fsm_if.master        bus
);

    localparam logic [3:0] S_RST      = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADDR  = 4'd3;
    localparam logic [3:0] S_MEMREAD  = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWRITE = 4'd6;
    localparam logic [3:0] S_RTYPE_EX = 4'd7;
    localparam logic [3:0] S_RTYPE_WB = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_ADDI_EX  = 4'd11;
    localparam logic [3:0] S_ADDI_WB  = 4'd12;
    localparam logic [3:0] S_ILLEGAL  = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 32'd1);

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctl_t;

    localparam ctl_t CTL_IDLE = 18'd0;

    logic [3:0] state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       illegal_op_q, illegal_op_d;
    ctl_t       ctl_q, ctl_d;

    // Next state and memory wait counter; the counter is cleared whenever the state moves on
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 4'd0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                if (wait_cnt_q >= LAST_WAIT) begin
                    state_d = S_DECODE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADDR: begin
                if (bus.opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                if (wait_cnt_q >= LAST_WAIT) begin
                    state_d = S_MEMWB;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_MEMWRITE: begin
                if (wait_cnt_q >= LAST_WAIT) begin
                    state_d = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_MEMWB, S_RTYPE_WB, S_BRANCH, S_JUMP, S_ADDI_WB, S_ILLEGAL: state_d = S_FETCH;
            default:    state_d = S_RST;
        endcase
    end

    // Output decode for the upcoming state so that the registered outputs line up with state_q
    always_comb begin
        ctl_d        = CTL_IDLE;
        illegal_op_d = illegal_op_q | (state_d == S_ILLEGAL);
        case (state_d)
            S_FETCH: begin
                ctl_d.mem_read  = 1'b1;
                ctl_d.alu_src_b = 3'b001;
                if (wait_cnt_d == LAST_WAIT) begin
                    ctl_d.ir_write = 1'b1;
                    ctl_d.pc_write = 1'b1;
                end else begin
                    ctl_d.ir_write = 1'b0;
                    ctl_d.pc_write = 1'b0;
                end
            end
            S_DECODE: ctl_d.alu_src_b = 3'b011;
            S_MEMADDR: begin
                ctl_d.alu_src_a = 1'b1;
                ctl_d.alu_src_b = 3'b010;
            end
            S_MEMREAD: begin
                ctl_d.mem_read = 1'b1;
                ctl_d.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctl_d.mem_to_reg = 1'b1;
                ctl_d.reg_write  = 1'b1;
                ctl_d.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctl_d.i_or_d = 1'b1;
                // One write strobe per store, however long the access is stretched
                if (wait_cnt_d == LAST_WAIT) begin
                    ctl_d.mem_write  = 1'b1;
                    ctl_d.instr_done = 1'b1;
                end else begin
                    ctl_d.mem_write  = 1'b0;
                    ctl_d.instr_done = 1'b0;
                end
            end
            S_RTYPE_EX: begin
                ctl_d.alu_src_a = 1'b1;
                ctl_d.alu_op    = 2'b10;
            end
            S_RTYPE_WB: begin
                ctl_d.reg_dst    = 1'b1;
                ctl_d.reg_write  = 1'b1;
                ctl_d.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctl_d.alu_src_a     = 1'b1;
                ctl_d.alu_op        = 2'b01;
                ctl_d.pc_write_cond = 1'b1;
                ctl_d.pc_source     = 2'b01;
                ctl_d.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctl_d.pc_write   = 1'b1;
                ctl_d.pc_source  = 2'b10;
                ctl_d.instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                ctl_d.alu_src_a = 1'b1;
                ctl_d.alu_src_b = 3'b010;
            end
            S_ADDI_WB: begin
                ctl_d.reg_write  = 1'b1;
                ctl_d.instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                ctl_d.alu_src_b  = 3'b100;
                ctl_d.instr_done = 1'b1;
            end
            default: ctl_d = CTL_IDLE;
        endcase
    end

    // State, counter, sticky flag and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RST;
            wait_cnt_q   <= 4'd0;
            illegal_op_q <= 1'b0;
            ctl_q        <= CTL_IDLE;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            illegal_op_q <= illegal_op_d;
            ctl_q        <= ctl_d;
        end
    end

    assign bus.PCWrite     = ctl_q.pc_write;
    assign bus.PCWriteCond = ctl_q.pc_write_cond;
    assign bus.IorD        = ctl_q.i_or_d;
    assign bus.MemRead     = ctl_q.mem_read;
    assign bus.MemWrite    = ctl_q.mem_write;
    assign bus.IRWrite     = ctl_q.ir_write;
    assign bus.MemtoReg    = ctl_q.mem_to_reg;
    assign bus.RegDst      = ctl_q.reg_dst;
    assign bus.RegWrite    = ctl_q.reg_write;
    assign bus.ALUSrcA     = ctl_q.alu_src_a;
    assign bus.ALUSrcB     = ctl_q.alu_src_b;
    assign bus.ALUOp       = ctl_q.alu_op;
    assign bus.PCSource    = ctl_q.pc_source;
    assign bus.instr_done  = ctl_q.instr_done;
    assign bus.illegal_op  = illegal_op_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: one instance with single-cycle memory, one with 3-cycle memory,
// each checked every cycle against an instruction-sequence model plus literal cycle-count checks.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
        logic [2:0] srcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       done;
    } ctl_t;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] tag;   // 1: opcode decides class here, 2: opcode decides lw/sw here
        ctl_t       c;
    } step_t;

    logic clk = 1'b0;
    logic rst1, rst3;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_fsm_if bus1 ();
    multicycle_control_fsm_if bus3 ();

    multicycle_control_fsm #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1.master));
    multicycle_control_fsm #(.MEM_LAT(3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3.master));

    always #5 clk = ~clk;

    ctl_t act_c1, act_c3;
    assign act_c1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.IorD, bus1.MemRead, bus1.MemWrite,
                     bus1.IRWrite, bus1.MemtoReg, bus1.RegDst, bus1.RegWrite, bus1.ALUSrcA,
                     bus1.ALUSrcB, bus1.ALUOp, bus1.PCSource, bus1.instr_done};
    assign act_c3 = {bus3.PCWrite, bus3.PCWriteCond, bus3.IorD, bus3.MemRead, bus3.MemWrite,
                     bus3.IRWrite, bus3.MemtoReg, bus3.RegDst, bus3.RegWrite, bus3.ALUSrcA,
                     bus3.ALUSrcB, bus3.ALUOp, bus3.PCSource, bus3.instr_done};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- instruction-sequence model ----------------
    step_t q0[$];
    step_t q1[$];
    step_t cur [2];
    logic  ill_exp [2];
    int    lat [2] = '{1, 3};

    task automatic push(input int k, input logic [3:0] st, input logic [1:0] tag, input ctl_t c);
        step_t s;
        s.st = st; s.tag = tag; s.c = c;
        if (k == 0) q0.push_back(s); else q1.push_back(s);
    endtask

    task automatic start_instr(input int k);
        ctl_t c;
        for (int i = 0; i < lat[k]; i++) begin
            c = '0; c.mrd = 1'b1; c.srcb = 3'b001;
            if (i == lat[k] - 1) begin c.irw = 1'b1; c.pcw = 1'b1; end
            push(k, 4'd1, 2'd0, c);
        end
        c = '0; c.srcb = 3'b011;
        push(k, 4'd2, 2'd1, c);
    endtask

    task automatic push_class(input int k, input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (op)
            6'b000000: begin
                c.srca = 1'b1; c.aluop = 2'b10; push(k, 4'd7, 2'd0, c);
                c = '0; c.rdst = 1'b1; c.rwr = 1'b1; c.done = 1'b1; push(k, 4'd8, 2'd0, c);
            end
            6'b100011, 6'b101011: begin
                c.srca = 1'b1; c.srcb = 3'b010; push(k, 4'd3, 2'd2, c);
            end
            6'b000100: begin
                c.srca = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'b01; c.done = 1'b1;
                push(k, 4'd9, 2'd0, c);
            end
            6'b000010: begin
                c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1; push(k, 4'd10, 2'd0, c);
            end
            6'b001000: begin
                c.srca = 1'b1; c.srcb = 3'b010; push(k, 4'd11, 2'd0, c);
                c = '0; c.rwr = 1'b1; c.done = 1'b1; push(k, 4'd12, 2'd0, c);
            end
            default: begin
                c.srcb = 3'b100; c.done = 1'b1; push(k, 4'd13, 2'd0, c);
            end
        endcase
    endtask

    task automatic push_mem(input int k, input logic [5:0] op);
        ctl_t c;
        for (int i = 0; i < lat[k]; i++) begin
            c = '0; c.iord = 1'b1;
            if (op == 6'b101011) begin
                if (i == lat[k] - 1) begin c.mwr = 1'b1; c.done = 1'b1; end
                push(k, 4'd6, 2'd0, c);
            end else begin
                c.mrd = 1'b1;
                push(k, 4'd4, 2'd0, c);
            end
        end
        if (op != 6'b101011) begin
            c = '0; c.m2r = 1'b1; c.rwr = 1'b1; c.done = 1'b1;
            push(k, 4'd5, 2'd0, c);
        end
    endtask

    // Compare at the falling edge, then advance the model with the inputs the next rising edge samples
    initial begin
        logic       model_valid;
        logic       r;
        logic [5:0] op;
        ctl_t       ac;
        logic [3:0] ast;
        logic       ail;
        model_valid = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ac  = (k == 0) ? act_c1 : act_c3;
                ast = (k == 0) ? bus1.state_dbg : bus3.state_dbg;
                ail = (k == 0) ? bus1.illegal_op : bus3.illegal_op;
                r   = (k == 0) ? rst1 : rst3;
                op  = (k == 0) ? bus1.opcode : bus3.opcode;
                if (model_valid) begin
                    chk($sformatf("dut%0d state_dbg", k), 32'(ast), 32'(cur[k].st));
                    chk($sformatf("dut%0d controls", k), 32'(ac), 32'(cur[k].c));
                    chk($sformatf("dut%0d illegal_op", k), 32'(ail), 32'(ill_exp[k]));
                end
                if (r) begin
                    if (k == 0) q0.delete(); else q1.delete();
                    cur[k]     = '0;
                    ill_exp[k] = 1'b0;
                end else begin
                    if (cur[k].tag == 2'd1) push_class(k, op);
                    else if (cur[k].tag == 2'd2) push_mem(k, op);
                    if (k == 0) begin
                        if (q0.size() == 0) start_instr(0);
                        cur[0] = q0.pop_front();
                    end else begin
                        if (q1.size() == 0) start_instr(1);
                        cur[1] = q1.pop_front();
                    end
                    if (cur[k].st == 4'd13) ill_exp[k] = 1'b1;
                end
            end
            model_valid = 1'b1;
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic wait_done(input int k, output int n, output int mw, output int irw);
        ctl_t c;
        n = 0; mw = 0; irw = 0;
        do begin
            @(posedge clk); #2;
            n++;
            c = (k == 0) ? act_c1 : act_c3;
            if (c.mwr) mw++;
            if (c.irw) irw++;
        end while (!c.done && n < 40);
        if (!c.done) begin
            checks++; errors++;
            $display("FAIL dut%0d instr_done timeout actual=none required=pulse", k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, mw, irw;
        rst1 = 1'b1; rst3 = 1'b1;
        bus1.opcode = 6'b000000;
        bus3.opcode = 6'b000000;
        repeat (3) @(posedge clk);
        #2;
        chk("t1 reset state", 32'(bus1.state_dbg), 32'd0);
        chk("t1 reset srcb", 32'(bus1.ALUSrcB), 32'd0);

        // T1: R-type after reset, done in the 4th cycle after RST
        rst1 = 1'b0;
        wait_done(0, n, mw, irw);
        chk("t1 cycles", 32'(n), 32'd4);
        chk("t1 state", 32'(bus1.state_dbg), 32'd8);
        chk("t1 regdst", 32'(bus1.RegDst), 32'd1);

        // T2: lw, single-cycle memory
        bus1.opcode = 6'b100011;
        wait_done(0, n, mw, irw);
        chk("t2 cycles", 32'(n), 32'd5);
        chk("t2 state", 32'(bus1.state_dbg), 32'd5);
        chk("t2 memtoreg", 32'(bus1.MemtoReg), 32'd1);

        // T4: beq then j
        bus1.opcode = 6'b000100;
        wait_done(0, n, mw, irw);
        chk("t4 beq cycles", 32'(n), 32'd3);
        chk("t4 pcwritecond", 32'(bus1.PCWriteCond), 32'd1);
        chk("t4 beq pcsource", 32'(bus1.PCSource), 32'd1);
        chk("t4 aluop", 32'(bus1.ALUOp), 32'd1);
        bus1.opcode = 6'b000010;
        wait_done(0, n, mw, irw);
        chk("t4 j cycles", 32'(n), 32'd3);
        chk("t4 pcwrite", 32'(bus1.PCWrite), 32'd1);
        chk("t4 j pcsource", 32'(bus1.PCSource), 32'd2);

        // T5: illegal opcode, sticky through addi, cleared by reset
        bus1.opcode = 6'b111111;
        wait_done(0, n, mw, irw);
        chk("t5 ill cycles", 32'(n), 32'd3);
        chk("t5 srcb", 32'(bus1.ALUSrcB), 32'd4);
        chk("t5 illegal set", 32'(bus1.illegal_op), 32'd1);
        bus1.opcode = 6'b001000;
        wait_done(0, n, mw, irw);
        chk("t5 addi cycles", 32'(n), 32'd4);
        chk("t5 illegal sticky", 32'(bus1.illegal_op), 32'd1);
        rst1 = 1'b1;
        @(posedge clk); #2;
        chk("t5 illegal cleared", 32'(bus1.illegal_op), 32'd0);
        chk("t5 reset state", 32'(bus1.state_dbg), 32'd0);

        // T3: sw with 3-cycle memory
        bus3.opcode = 6'b101011;
        rst3 = 1'b0;
        wait_done(1, n, mw, irw);
        chk("t3 cycles", 32'(n), 32'd8);
        chk("t3 memwrite pulses", 32'(mw), 32'd1);
        chk("t3 irwrite pulses", 32'(irw), 32'd1);

        bus3.opcode = 6'b100011;
        wait_done(1, n, mw, irw);
        chk("l3 lw cycles", 32'(n), 32'd9);
        bus3.opcode = 6'b000000;
        wait_done(1, n, mw, irw);
        chk("l3 rtype cycles", 32'(n), 32'd6);

        // T6: reset in the 2nd MEMWRITE cycle aborts the store
        bus3.opcode = 6'b101011;
        mw = 0;
        repeat (7) begin
            @(posedge clk); #2;
            if (bus3.MemWrite) mw++;
        end
        chk("t6 in memwrite", 32'(bus3.state_dbg), 32'd6);
        rst3 = 1'b1;
        @(posedge clk); #2;
        if (bus3.MemWrite) mw++;
        chk("t6 reset state", 32'(bus3.state_dbg), 32'd0);
        chk("t6 outputs idle", 32'(act_c3), 32'd0);
        chk("t6 no memwrite", 32'(mw), 32'd0);
        rst3 = 1'b0;
        bus3.opcode = 6'b000000;
        wait_done(1, n, mw, irw);
        chk("t6 restart cycles", 32'(n), 32'd6);

        repeat (2) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
